// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the PCIe physical-layer lane model.
package pcie_phy_pkg;

    // Alignment / idle symbol.
    localparam logic [7:0] COM_SYM = 8'hBC;

    // Default number of consecutive aligned COM bytes needed to go ACTIVE.
    localparam int unsigned COM_COUNT_DEFAULT = 4;

    // Width of the COM run counter (covers 1..15).
    localparam int unsigned COM_CNT_W = 4;

    // Width of the in-byte bit counter.
    localparam int unsigned BIT_CNT_W = 3;

    // Receive deserializer states.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_to_parallel_rx.sv
// MSB-first serial-to-parallel receiver that locks byte alignment on a run of COM symbols.
module serial_to_parallel_rx
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0]  COM       = COM_SYM,
    parameter int unsigned COM_COUNT = COM_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [COM_CNT_W-1:0] COM_TARGET = COM_CNT_W'(COM_COUNT);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(7);

    rx_state_e              state_q, state_d;
    logic [7:0]             sr_q, sr_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [COM_CNT_W-1:0]   com_cnt_q, com_cnt_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   strobe_q, strobe_d;
    logic                   active_q, active_d;

    logic [7:0]             nxt;
    logic                   is_com;
    logic                   boundary;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= 8'h00;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    // Alignment search, COM run counting and byte emission.
    always_comb begin
        nxt       = {sr_q[6:0], serial_in};
        is_com    = (nxt == COM);
        boundary  = (bit_cnt_q == BIT_LAST);

        state_d   = state_q;
        sr_d      = nxt;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;

        unique case (state_q)
            SEARCH: begin
                // Sliding bit-granular match; the counter restarts on the matching edge.
                bit_cnt_d = '0;
                com_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = COM_CNT_W'(1);
                    state_d   = (COM_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + COM_CNT_W'(1);
                        if (com_cnt_d == COM_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        // Drop alignment; sr keeps the bits so a straddling COM is still found.
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d   = nxt;
                    strobe_d = 1'b1;
                    valid_d  = !is_com;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        active_d = (state_d == ACTIVE);
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Scoreboard bench for serial_to_parallel_rx (default COM_COUNT and COM_COUNT=1 instances).
`timescale 1ns/1ps
module tb_serial_to_parallel_rx;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst1 = 1'b1;
    logic       serial_in = 1'b0;

    logic [7:0] data0, data1;
    logic       valid0, valid1, strobe0, strobe1, act0, act1;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic        hold0 = 1'b0;
    logic [7:0]  hold_d0;
    logic        hold_v0;
    logic        have_last0 = 1'b0;
    int unsigned last0;
    int          n_strobe0 = 0;
    int          saved_strobes;

    serial_to_parallel_rx dut (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .data_out(data0), .valid_out(valid0), .byte_strobe(strobe0), .active(act0)
    );

    serial_to_parallel_rx #(.COM(8'hBC), .COM_COUNT(1)) dut1 (
        .clk(clk), .reset(rst1), .serial_in(serial_in),
        .data_out(data1), .valid_out(valid1), .byte_strobe(strobe1), .active(act1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Main instance: pop expectations on strobe, check spacing and hold between strobes.
    always @(negedge clk) begin
        if (reset) begin
            hold0      = 1'b0;
            have_last0 = 1'b0;
        end else if (strobe0) begin
            n_strobe0++;
            if (have_last0) chk("strobe_gap", 32'(cyc - last0), 32'd8);
            last0      = cyc;
            have_last0 = 1'b1;
            if (q0.size() == 0) begin
                chk("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("data", 32'(data0), 32'(e0.d));
                chk("valid", 32'(valid0), 32'(e0.v));
                hold_d0 = e0.d;
                hold_v0 = e0.v;
                hold0   = 1'b1;
            end
        end else if (hold0) begin
            chk("hold_data", 32'(data0), 32'(hold_d0));
            chk("hold_valid", 32'(valid0), 32'(hold_v0));
        end
    end

    // COM_COUNT=1 instance monitor.
    always @(negedge clk) begin
        if (!rst1 && strobe1) begin
            if (q1.size() == 0) begin
                chk("c1_strobe_unexpected", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("c1_data", 32'(data1), 32'(e1.d));
                chk("c1_valid", 32'(valid1), 32'(e1.v));
            end
        end
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic push0(input logic [7:0] d, input logic v);
        exp_t x;
        x.d = d;
        x.v = v;
        q0.push_back(x);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_data"}, 32'(data0), 32'h00);
        chk({tag, "_valid"}, 32'(valid0), 32'd0);
        chk({tag, "_strobe"}, 32'(strobe0), 32'd0);
        chk({tag, "_active"}, 32'(act0), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("rst");
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random line activity.
        repeat (5) begin
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1;
        chk_cleared("por");
        reset = 1'b0;

        // Four aligned COMs: active rises on the 32nd bit edge.
        repeat (3) send_byte(8'hBC);
        send_bits(8'hBC, 7);
        chk("p1_active_bit31", 32'(act0), 32'd0);
        send_bit(1'b0);
        chk("p1_active_bit32", 32'(act0), 32'd1);
        chk("p1_data_unchanged", 32'(data0), 32'h00);
        chk("p1_valid_unchanged", 32'(valid0), 32'd0);

        // Junk lead-in, then lock and payload.
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(8'hBC);
        chk("p2_active", 32'(act0), 32'd1);
        push0(8'h5A, 1'b1);
        push0(8'hC3, 1'b1);
        send_byte(8'h5A);
        send_byte(8'hC3);

        // Broken COM run falls back to SEARCH; relock only after a full run.
        do_reset();
        repeat (2) send_byte(8'hBC);
        send_byte(8'h00);
        chk("p3_active_after_break", 32'(act0), 32'd0);
        repeat (3) send_byte(8'hBC);
        send_bits(8'hBC, 7);
        chk("p3_active_pre", 32'(act0), 32'd0);
        send_bit(1'b0);
        chk("p3_active_relock", 32'(act0), 32'd1);

        // Payload with embedded idle COM.
        push0(8'h12, 1'b1);
        push0(8'hBC, 1'b0);
        push0(8'h34, 1'b1);
        send_byte(8'h12);
        send_byte(8'hBC);
        send_byte(8'h34);

        // Asynchronous reset mid-byte.
        send_bits(8'h77, 4);
        #2;
        reset = 1'b1;
        #1;
        chk_cleared("async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        saved_strobes = n_strobe0;
        send_byte(8'h5A);
        repeat (8) send_bit(1'b0);
        chk("p5_no_strobe", 32'(n_strobe0), 32'(saved_strobes));
        chk("p5_active", 32'(act0), 32'd0);

        // COM_COUNT=1 instance: one COM locks, next byte is payload.
        rst1 = 1'b0;
        send_bits(8'hBC, 7);
        chk("c1_active_pre", 32'(act1), 32'd0);
        send_bit(1'b0);
        chk("c1_active", 32'(act1), 32'd1);
        begin
            exp_t x;
            x.d = 8'hFF;
            x.v = 1'b1;
            q1.push_back(x);
        end
        send_byte(8'hFF);
        chk("c1_data_direct", 32'(data1), 32'hFF);
        chk("c1_valid_direct", 32'(valid1), 32'd1);
        repeat (2) send_bit(1'b0);
        chk("c1_main_active", 32'(act0), 32'd0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
